// File: rtl/im_loader.sv
// Byte-serial program loader for the instruction memory.
// Frames: LEN(16, BE) | 4*LEN data bytes | XOR checksum.
module im_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h00003000,
  parameter int          DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR
  } state_t;

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] wcnt;
  logic [1:0]  bcnt;
  logic [7:0]  xsum;
  logic [23:0] acc;

  logic        take;
  logic [15:0] n;
  logic        bad_len;
  logic [31:0] waddr;

  assign take    = in_valid & in_ready;
  assign n       = {len_hi, in_data};
  assign bad_len = (n == 16'd0) ||
                   (32'(n) > 32'(DEPTH));
  assign waddr   = BASE_ADDR +
                   {14'd0, wcnt, 2'b00};

  // Frame sequencer; every output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len_hi   <= '0;
      len      <= '0;
      wcnt     <= '0;
      bcnt     <= '0;
      xsum     <= '0;
      acc      <= '0;
      in_ready <= 1'b0;
      im_we    <= 1'b0;
      im_addr  <= BASE_ADDR;
      im_wdata <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      im_we <= 1'b0;
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= LEN_HI;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            in_ready <= 1'b1;
            xsum     <= '0;
            wcnt     <= '0;
            bcnt     <= '0;
          end
        end
        LEN_HI: begin
          if (take) begin
            len_hi <= in_data;
            xsum   <= xsum ^ in_data;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (take) begin
            len  <= n;
            xsum <= xsum ^ in_data;
            if (bad_len) begin
              state    <= ERR;
              busy     <= 1'b0;
              err      <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (take) begin
            xsum <= xsum ^ in_data;
            bcnt <= bcnt + 2'd1;
            acc  <= {acc[15:0], in_data};
            if (bcnt == 2'd3) begin
              im_we    <= 1'b1;
              im_addr  <= waddr;
              im_wdata <= {acc, in_data};
              wcnt     <= wcnt + 16'd1;
              if (wcnt == len - 16'd1)
                state <= CSUM;
            end
          end
        end
        CSUM: begin
          if (take) begin
            busy     <= 1'b0;
            in_ready <= 1'b0;
            if (in_data == xsum) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: expected writes and
// completion status are queued, a monitor pops them.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t        wq[$];
  logic [1:0] sq[$];
  wr_t        ew;
  logic [1:0] es;
  logic       prev_we = 1'b0;
  logic       prev_fin = 1'b0;

  logic [7:0] dat [0:7] = '{
    8'h12, 8'h34, 8'h56, 8'h78,
    8'h9A, 8'hBC, 8'hDE, 8'hF0
  };

  im_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: pop expectations as the DUT produces output.
  always @(negedge clk) begin
    if (rst_n) begin
      if (im_we) begin
        chk("we_single", {31'd0, prev_we}, 32'd0);
        if (wq.size() == 0) begin
          fail("unexpected_write");
        end else begin
          ew = wq.pop_front();
          chk("im_addr", im_addr, ew.a);
          chk("im_wdata", im_wdata, ew.d);
        end
      end
      if ((done | err) && !prev_fin) begin
        if (sq.size() == 0) begin
          fail("unexpected_status");
        end else begin
          es = sq.pop_front();
          chk("status_done_err", {30'd0, done, err},
              {30'd0, es});
          chk("busy_at_end", {31'd0, busy}, 32'd0);
          chk("writes_before_end", wq.size(), 32'd0);
        end
      end
    end
    prev_we  <= rst_n & im_we;
    prev_fin <= rst_n & (done | err);
  end

  task automatic send(input logic [7:0] b,
                      input bit stall);
    if (stall) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'hA5;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20 && !in_ready; i++)
      @(negedge clk);
    if (!in_ready) fail("ready_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("ready_after_start", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic load(input logic [7:0] cs,
                      input int nb,
                      input bit stall,
                      input bit pulse);
    send(8'h00, stall);
    send(8'h02, stall);
    for (int i = 0; i < nb; i++) begin
      if (pulse && i == 2) start = 1'b1;
      send(dat[i], stall);
      start = 1'b0;
    end
    if (nb == 8) send(cs, stall);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_end();
    for (int i = 0; i < 20 && sq.size() != 0; i++)
      @(negedge clk);
    if (sq.size() != 0) begin
      fail("status_timeout");
      sq.delete();
    end
  endtask

  task automatic push_words(input int n);
    if (n > 0) wq.push_back({32'h00003000, 32'h12345678});
    if (n > 1) wq.push_back({32'h00003004, 32'h9ABCDEF0});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_im_we"}, {31'd0, im_we}, 32'd0);
    chk({tag, "_im_addr"}, im_addr, 32'h00003000);
    chk({tag, "_im_wdata"}, im_wdata, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    push_words(2);
    sq.push_back(2'b10);
    do_start();
    load(8'h02, 8, 1'b0, 1'b0);
    idle();
    wait_end();
    chk("good_done", {31'd0, done}, 32'd1);
    chk("good_ready", {31'd0, in_ready}, 32'd0);

    push_words(2);
    sq.push_back(2'b10);
    do_start();
    load(8'h02, 8, 1'b1, 1'b0);
    idle();
    wait_end();

    push_words(2);
    sq.push_back(2'b01);
    do_start();
    load(8'h03, 8, 1'b0, 1'b0);
    idle();
    wait_end();
    chk("badcs_done", {31'd0, done}, 32'd0);

    sq.push_back(2'b01);
    do_start();
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    idle();
    chk("len0_err", {31'd0, err}, 32'd1);
    chk("len0_ready", {31'd0, in_ready}, 32'd0);
    wait_end();

    sq.push_back(2'b01);
    do_start();
    send(8'h04, 1'b0);
    send(8'h01, 1'b0);
    idle();
    chk("len1025_err", {31'd0, err}, 32'd1);
    chk("len1025_busy", {31'd0, busy}, 32'd0);
    wait_end();

    push_words(1);
    do_start();
    load(8'h02, 6, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    chk("midrst_writes", wq.size(), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    push_words(2);
    sq.push_back(2'b10);
    do_start();
    load(8'h02, 8, 1'b0, 1'b1);
    idle();
    wait_end();
    chk("restart_done", {31'd0, done}, 32'd1);

    repeat (3) @(negedge clk);
    chk("wq_empty", wq.size(), 32'd0);
    chk("sq_empty", sq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/im_loader.md
# im_loader

Program loader that writes a byte-serial program image into the instruction memory before the processor runs. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and issues one write per word to the IM write port at consecutive word addresses starting at the reset PC. It also checks a trailing XOR checksum and reports completion or error.

## Interface
- BASE_ADDR, 32'h00003000, byte address of the first written word (the reset PC).
- DEPTH, 1024, IM capacity in words; maximum accepted word count.

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- im_we  out  1  one-cycle IM write strobe.
- im_addr  out  32  IM byte address of the write, word-aligned.
- im_wdata  out  32  word to write.
- busy  out  1  load in progress; holds the CPU in reset while high.
- done  out  1  last load completed with a good checksum.
- err  out  1  last load aborted: bad length or bad checksum.

## Operation
- Frame, big-endian: LEN_HI, LEN_LO (16-bit word count N), then 4N data bytes (MSB first per word), then CSUM = XOR of every preceding frame byte, LEN bytes included.
- A byte transfers on a rising edge where in_valid && in_ready.
- States:
  - IDLE: in_ready=0; start -> LEN_HI, busy=1, done=0, err=0.
  - LEN_HI: capture high byte -> LEN_LO.
  - LEN_LO: capture low byte; N==0 or N>DEPTH -> ERR; otherwise -> DATA.
  - DATA: shift byte into the assembly register; on the 4th byte of a word, register the write (see Timing); after word N-1's 4th byte -> CSUM.
  - CSUM: compare the received byte with the running XOR; equal -> DONE, else -> ERR.
  - DONE: busy=0, done=1, in_ready=0; start -> LEN_HI.
  - ERR: busy=0, err=1, in_ready=0; start -> LEN_HI.
- in_ready=1 in LEN_HI, LEN_LO, DATA and CSUM, independent of in_valid.
- Word counter is 16 bits; address = BASE_ADDR + 4*k for word k, with 32-bit wrap (no saturation).
- Running XOR clears on start; byte counter within a word is 2 bits and wraps.
- start is ignored in LEN_HI, LEN_LO, DATA and CSUM.
- Words already written before an ERR remain in IM; the loader does not roll them back.

## Timing
- Reset values: in_ready=0, im_we=0, im_addr=BASE_ADDR, im_wdata=0, busy=0, done=0, err=0, state IDLE; internal counters and XOR cleared.
- start sampled high in IDLE/DONE/ERR: busy=1 and in_ready=1 from the next cycle.
- Write latency: the edge that accepts the 4th byte of word k registers im_we=1, im_addr=BASE_ADDR+4k and im_wdata, visible for exactly the following cycle.
- im_we never stays high more than one cycle.
- No stall during the write cycle, so back-to-back words give im_we every 4th cycle at full rate.
- in_valid low inserts idle cycles; nothing advances.
- LEN_LO with an illegal N: ERR from the next cycle, no im_we.
- CSUM byte accepted: done or err asserts and busy drops on the next cycle. The final word's im_we coincides with the CSUM state and precedes done by at least one cycle.
- Asynchronous reset mid-load: every output returns to its reset value immediately, including a pending im_we; the loader resumes in IDLE.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 -> all outputs at reset values, im_addr=32'h00003000, no im_we.
- Good load: start, then 00 02, 12 34 56 78, 9A BC DE F0, CSUM=0x02 at full rate -> im_we at 0x3000 with 0x12345678, then at 0x3004 with 0x9ABCDEF0; done=1, busy=0, err=0.
- Stalled stream: same frame with in_valid toggling 1/0 -> identical writes and done; in_valid low never advances.
- Bad checksum: same frame with CSUM=0x03 -> both writes occur, then err=1, done=0.
- Illegal length: frames with LEN 00 00 and with LEN 04 01 (1025) -> err=1 right after LEN_LO, zero im_we.
- Reset mid-load and restart: assert rst_n=0 after 6 data bytes -> outputs reset asynchronously; start again and send the good frame -> done=1; start pulses during DATA are ignored.
